// File: rtl/prim_clock_mux_ctrl.sv
// Glitch-free clock mux sequencer: gates the downstream clock off, flips
// the mux select, gates the clock back on, then pulses ack_o once.
// Ports:
//   clk_i     - sole clock, all state updates on its rising edge
//   rst_i     - asynchronous active-high reset
//   req_i     - switch request, sampled only in IDLE
//   sel_req_i - requested mux select, captured together with req_i
//   ack_o     - one-cycle completion pulse
//   busy_o    - high whenever the sequencer is not IDLE
//   sel_o     - select to the downstream clock mux
//   clk_en_o  - enable for the clock gate after the mux
module prim_clock_mux_ctrl #(
  parameter int unsigned SettleCycles = 4,
  parameter logic        ResetSel     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic sel_req_i,
  output logic ack_o,
  output logic busy_o,
  output logic sel_o,
  output logic clk_en_o
);

  typedef enum logic [2:0] {
    IDLE,
    GATE_OFF,
    SWITCH,
    GATE_ON,
    ACK
  } state_t;

  // Value loaded on entry to each settle phase; the phase lasts
  // until the counter has been seen at zero.
  localparam logic [7:0] Load = 8'(SettleCycles - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       target;
  logic       done;

  assign done = (cnt == 8'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      target   <= ResetSel;
      sel_o    <= ResetSel;
      clk_en_o <= 1'b1;
      ack_o    <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_i) begin
            target <= sel_req_i;
            busy_o <= 1'b1;
            if (sel_req_i != sel_o) begin
              state    <= GATE_OFF;
              clk_en_o <= 1'b0;
              cnt      <= Load;
            end else begin
              // Already on the requested clock: acknowledge only.
              state <= ACK;
              ack_o <= 1'b1;
            end
          end
        end
        GATE_OFF: begin
          if (done) begin
            state <= SWITCH;
            sel_o <= target;
            cnt   <= Load;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SWITCH: begin
          if (done) begin
            state    <= GATE_ON;
            clk_en_o <= 1'b1;
            cnt      <= Load;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GATE_ON: begin
          if (done) begin
            state <= ACK;
            ack_o <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACK: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
